// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock, start/done handshake.
// Divide-by-zero finishes immediately with quotient all ones and remainder = dividend.
module seq_divider #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    // state  | meaning
    // S_IDLE | waiting for start, ready=1
    // S_CALC | shifting/subtracting, one quotient bit per edge, busy=1
    // S_DONE | results valid, done=1 for one cycle
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    localparam int CW = (N > 2) ? $clog2(N) : 1;

    state_t        state;
    logic [N-1:0]  q_reg;
    logic [N-1:0]  d_reg;
    logic [N-1:0]  r_reg;
    logic [CW-1:0] cnt;

    logic [N:0]    shifted;
    logic [N:0]    diff;
    logic [N-1:0]  r_next;
    logic [N-1:0]  q_next;

    // The partial remainder is always < divisor, so only the trial subtract needs N+1 bits.
    always_comb begin
        shifted = {r_reg, q_reg[N-1]};
        diff    = shifted - {1'b0, d_reg};
        r_next  = shifted[N-1:0];
        q_next  = {q_reg[N-2:0], 1'b0};
        if (!diff[N]) begin
            r_next = diff[N-1:0];
            q_next = {q_reg[N-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            ready       <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            q_reg       <= '0;
            d_reg       <= '0;
            r_reg       <= '0;
            cnt         <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        ready <= 1'b0;
                        if (divisor != '0) begin
                            q_reg       <= dividend;
                            d_reg       <= divisor;
                            r_reg       <= '0;
                            cnt         <= CW'(N - 1);
                            div_by_zero <= 1'b0;
                            busy        <= 1'b1;
                            state       <= S_CALC;
                        end else begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            state       <= S_DONE;
                        end
                    end
                end
                S_CALC: begin
                    q_reg <= q_next;
                    r_reg <= r_next;
                    cnt   <= cnt - CW'(1);
                    if (cnt == '0) begin
                        quotient  <= q_next;
                        remainder <= r_next;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= S_IDLE;
                end
                default: begin
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases plus random operands against a
// plain-arithmetic reference (a / b, a % b, all-ones on divide by zero).
module tb_seq_divider;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         ready;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    int n_checks = 0;
    int n_pass   = 0;
    logic [N-1:0] last_q;
    logic [N-1:0] last_r;

    seq_divider #(.N(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .ready       (ready),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic void model(input logic [N-1:0] a, input logic [N-1:0] b,
                                  output logic [N-1:0] q, output logic [N-1:0] r,
                                  output logic z);
        if (b == 0) begin
            q = {N{1'b1}};
            r = a;
            z = 1'b1;
        end else begin
            q = a / b;
            r = a % b;
            z = 1'b0;
        end
    endfunction

    // Counts negedges until done; results must hold their old values while busy.
    task automatic wait_done(output int cyc, output int bsy);
        bit seen;
        seen = 0;
        cyc  = 0;
        bsy  = 0;
        while (!seen && cyc < 30) begin
            @(negedge clk);
            cyc++;
            check("one_hot", 32'(ready) + 32'(busy) + 32'(done), 1);
            if (busy) begin
                bsy++;
                check("q_hold", quotient, last_q);
                check("r_hold", remainder, last_r);
            end
            if (done) seen = 1;
        end
        if (!seen) check("done_timeout", 0, 1);
    endtask

    task automatic check_result(input logic [N-1:0] a, input logic [N-1:0] b,
                                input int cyc, input int bsy);
        logic [N-1:0] eq, er;
        logic         ez;
        model(a, b, eq, er, ez);
        check("quotient", quotient, eq);
        check("remainder", remainder, er);
        check("div_by_zero", div_by_zero, ez);
        check("latency", cyc, (b == 0) ? 1 : N + 1);
        check("busy_cycles", bsy, (b == 0) ? 0 : N);
        if (b != 0) begin
            check("invariant", 32'(quotient) * 32'(b) + 32'(remainder), a);
            check("rem_lt_div", 32'(remainder < b), 1);
        end
        last_q = eq;
        last_r = er;
        @(negedge clk);
        check("done_pulse", done, 0);
        check("ready_after", ready, 1);
    endtask

    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b);
        int cyc, bsy;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = N'($urandom);
        divisor  = N'($urandom);
        wait_done(cyc, bsy);
        check_result(a, b, cyc, bsy);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc, bsy;
        logic [N-1:0] a, b;

        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        last_q   = '0;
        last_r   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_dbz", div_by_zero, 0);
        reset = 1'b0;
        @(negedge clk);

        do_op(100, 7);
        do_op(255, 1);
        do_op(5, 9);
        do_op(0, 3);
        do_op(255, 255);
        do_op(42, 0);
        do_op(9, 3);

        // start held high, operands changed mid-operation
        start    = 1'b1;
        dividend = 200;
        divisor  = 3;
        @(posedge clk);
        #1;
        dividend = 10;
        divisor  = 2;
        wait_done(cyc, bsy);
        check_result(200, 3, cyc, bsy);
        wait_done(cyc, bsy);
        start = 1'b0;
        check_result(10, 2, cyc, bsy);

        // reset in the 4th CALC cycle abandons the operation
        start    = 1'b1;
        dividend = 150;
        divisor  = 4;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_reset_busy", busy, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_ready", ready, 1);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_quotient", quotient, 0);
        check("abort_remainder", remainder, 0);
        check("abort_dbz", div_by_zero, 0);
        last_q = '0;
        last_r = '0;
        repeat (12) begin
            @(negedge clk);
            check("no_done_after_reset", done, 0);
        end
        do_op(150, 4);

        for (int i = 0; i < 1000; i++) begin
            a = N'($urandom_range(0, (1 << N) - 1));
            b = ($urandom_range(0, 15) == 0) ? '0 : N'($urandom_range(1, (1 << N) - 1));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_op(a, b);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
